// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU front-end types and constants
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_PEND = 2'd1,
    HALTED     = 2'd2
  } fetch_state_t;

  localparam word_t PC_INCR = 32'd4;

  // Instruction addresses are word aligned; low bits of a target are dropped.
  function automatic word_t word_align(input word_t a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (inc && (count_q != {WIDTH{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, icache request, redirect absorption
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload_in,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic [31:0] PC,
  output logic [31:0] npc,
  output logic        flushed,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        tgt_q, tgt_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:        if (!ihit && redirect_en) state_d = REDIR_PEND;
      REDIR_PEND: if (ihit) state_d = RUN;
      HALTED:     state_d = HALTED;
      default:    state_d = RUN;
    endcase
    if (halt)
      state_d = HALTED;
  end

  always_comb begin
    imemREN = (state_q != HALTED);
    flushed = imemREN && ihit && (redirect_en || (state_q == REDIR_PEND));
  end

  // PC only moves on a hit so the icache address stays stable across a miss;
  // a redirect seen during a miss is parked in tgt_q until the hit arrives.
  always_comb begin
    pc_d  = pc_q;
    tgt_d = tgt_q;
    if (state_q != HALTED) begin
      if (ihit) begin
        if (flushed)
          pc_d = redirect_en ? word_align(redirect_addr) : tgt_q;
        else if (!stall)
          pc_d = pc_q + PC_INCR;
      end else if (redirect_en) begin
        tgt_d = word_align(redirect_addr);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q  <= PC_RESET;
      tgt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      tgt_q <= tgt_d;
    end
  end

  assign imemaddr = pc_q;
  assign PC       = pc_q;
  assign npc      = pc_q + PC_INCR;
  assign imemload = imemload_in;

  logic fetch_inc, flush_inc;
  assign fetch_inc = ihit && !flushed && !stall && imemREN;
  assign flush_inc = ihit && flushed;

  sat_counter #(.WIDTH(32)) u_fetch_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (fetch_inc),
    .clear (1'b0),
    .count (fetch_cnt)
  );

  sat_counter #(.WIDTH(32)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush_inc),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a behavioural model
module tb_fetch_unit;

  localparam logic [31:0] PC_RST = 32'h0000_0040;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload_in = '0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        halt = 1'b0;
  logic        imemREN;
  logic [31:0] imemaddr, imemload, PC, npc, fetch_cnt, flush_cnt;
  logic        flushed;

  fetch_unit #(.PC_RESET(PC_RST)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ihit          (ihit),
    .imemload_in   (imemload_in),
    .stall         (stall),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .imemload      (imemload),
    .PC            (PC),
    .npc           (npc),
    .flushed       (flushed),
    .fetch_cnt     (fetch_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a pending-redirect flag, a halted flag and plain counters.
  bit          m_pend, m_halt;
  logic [31:0] m_pc, m_tgt, m_fetch, m_flush;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic bit m_flushed();
    return !m_halt && ihit && (redirect_en || m_pend);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_halt = 0; m_pc = PC_RST; m_tgt = '0; m_fetch = '0; m_flush = '0;
  endtask

  task automatic model_step();
    if (!m_halt) begin
      if (ihit) begin
        if (m_flushed()) begin
          m_pc   = redirect_en ? align(redirect_addr) : m_tgt;
          m_pend = 0;
          if (m_flush != 32'hFFFF_FFFF) m_flush++;
        end else if (!stall) begin
          m_pc = m_pc + 32'd4;
          if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
        end
      end else if (redirect_en) begin
        m_tgt  = align(redirect_addr);
        m_pend = 1;
      end
      if (halt) m_halt = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("imemREN",  {31'd0, imemREN}, {31'd0, !m_halt});
    check_eq("imemaddr", imemaddr, m_pc);
    check_eq("PC",       PC, m_pc);
    check_eq("npc",      npc, m_pc + 32'd4);
    check_eq("flushed",  {31'd0, flushed}, {31'd0, m_flushed()});
    check_eq("imemload", imemload, imemload_in);
    check_eq("fetch_cnt", fetch_cnt, m_fetch);
    check_eq("flush_cnt", flush_cnt, m_flush);
  endtask

  task automatic drive(input bit ih, input bit st, input bit re, input logic [31:0] ra, input bit hl);
    ihit = ih; stall = st; redirect_en = re; redirect_addr = ra; halt = hl;
    imemload_in = $urandom;
    #1;
  endtask

  task automatic advance();
    compare_all();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    ihit = 0; redirect_en = 0; halt = 0; stall = 0;
    nRST = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge CLK);
    nRST = 1;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    compare_all();
    nRST = 1;
    #1;

    // Sequential fetch from reset
    check_eq("rst_addr", imemaddr, 32'h40);
    check_eq("rst_fetch", fetch_cnt, 32'd0);
    drive(1, 0, 0, 0, 0); advance(); check_eq("seq1", imemaddr, 32'h44);
    drive(1, 0, 0, 0, 0); advance(); check_eq("seq2", imemaddr, 32'h48);
    drive(1, 0, 0, 0, 0); advance(); check_eq("seq3", imemaddr, 32'h4C);
    check_eq("seq_npc", npc, 32'h50);
    check_eq("seq_fetch", fetch_cnt, 32'd3);

    // Stall holds PC and fetch count
    do_reset();
    drive(1, 0, 0, 0, 0); advance();
    drive(1, 1, 0, 0, 0); advance(); check_eq("stall1", imemaddr, 32'h44);
    drive(1, 1, 0, 0, 0); advance(); check_eq("stall2", imemaddr, 32'h44);
    check_eq("stall_fetch", fetch_cnt, 32'd1);
    drive(1, 0, 0, 0, 0); advance(); check_eq("unstall", imemaddr, 32'h48);

    // Redirect on a hit
    drive(1, 0, 1, 32'h100, 0);
    check_eq("hit_redir_flushed", {31'd0, flushed}, 32'd1);
    advance();
    check_eq("hit_redir_addr", imemaddr, 32'h100);
    check_eq("hit_redir_flush", flush_cnt, 32'd1);

    // Miss with two redirects; latest wins
    drive(1, 0, 1, 32'h20, 0); advance();
    drive(0, 0, 1, 32'h200, 0); advance(); check_eq("miss1", imemaddr, 32'h20);
    drive(0, 0, 0, 0, 0);       advance(); check_eq("miss2", imemaddr, 32'h20);
    drive(0, 0, 1, 32'h300, 0); advance(); check_eq("miss3", imemaddr, 32'h20);
    drive(0, 0, 0, 0, 0);       advance(); check_eq("miss4", imemaddr, 32'h20);
    drive(1, 0, 0, 0, 0);
    check_eq("miss_hit_flushed", {31'd0, flushed}, 32'd1);
    advance();
    check_eq("miss_target", imemaddr, 32'h300);
    check_eq("miss_flush_cnt", flush_cnt, 32'd3);

    // Wrap and alignment
    drive(1, 0, 1, 32'hFFFF_FFFC, 0); advance();
    check_eq("wrap_npc", npc, 32'h0);
    drive(1, 0, 0, 0, 0); advance(); check_eq("wrap_pc", imemaddr, 32'h0);
    drive(1, 0, 1, 32'h103, 0); advance(); check_eq("align", imemaddr, 32'h100);

    // Asynchronous reset in the middle of a miss
    drive(0, 0, 1, 32'h700, 0); advance();
    drive(0, 0, 0, 0, 0); advance();
    #1 nRST = 0;
    model_reset();
    #1;
    check_eq("async_rst_addr", imemaddr, PC_RST);
    check_eq("async_rst_flush", flush_cnt, 32'd0);
    check_eq("async_rst_fetch", fetch_cnt, 32'd0);
    @(negedge CLK);
    nRST = 1;
    #1;
    check_eq("post_rst_addr", imemaddr, PC_RST);
    check_eq("post_rst_ren", {31'd0, imemREN}, 32'd1);
    drive(1, 0, 0, 0, 0); advance();
    check_eq("post_rst_fetch", imemaddr, 32'h44);

    // Halt freezes the front end
    drive(1, 0, 0, 0, 1); advance();
    check_eq("halt_ren", {31'd0, imemREN}, 32'd0);
    check_eq("halt_pc", imemaddr, 32'h48);
    drive(1, 0, 1, 32'h500, 0);
    check_eq("halt_flushed", {31'd0, flushed}, 32'd0);
    advance();
    check_eq("halt_ignore_redir", imemaddr, 32'h48);

    // Halt + redirect + hit together
    do_reset();
    drive(1, 0, 1, 32'h600, 1);
    check_eq("hrh_flushed", {31'd0, flushed}, 32'd1);
    advance();
    check_eq("hrh_pc", imemaddr, 32'h600);
    check_eq("hrh_ren", {31'd0, imemREN}, 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0 || (m_halt && $urandom_range(0, 7) == 0)) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 15, $urandom, $urandom_range(0, 399) == 0);
        advance();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipeline: owns the PC, issues instruction requests to the icache, and produces the `imemload`/`npc`/`PC`/`flushed` bundle consumed by the IF/ID latch. It absorbs redirects from branch/jump resolution, including redirects that arrive while an icache miss is outstanding. It also maintains saturating fetch and flush counters for performance reporting.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  icache returns valid data for `imemaddr` this cycle
- imemload_in  in  32  icache read data
- stall  in  1  hazard unit holds the front end
- redirect_en  in  1  branch taken / jump resolved this cycle
- redirect_addr  in  32  redirect target
- halt  in  1  halt retired downstream
- imemREN  out  1  icache read enable
- imemaddr  out  32  icache read address (= PC)
- imemload  out  32  instruction to IF/ID (= imemload_in)
- PC  out  32  address of the fetched instruction
- npc  out  32  PC + 4
- flushed  out  1  the instruction returning this cycle is wrong-path; IF/ID loads a bubble
- fetch_cnt  out  32  delivered instructions, saturating
- flush_cnt  out  32  discarded instructions, saturating

## Operation
- States: RUN, REDIR_PEND, HALTED. Reset state is RUN, PC = PC_RESET, buffered target = 0, both counters = 0.
- imemREN = 1 in RUN and REDIR_PEND, 0 in HALTED. imemaddr = PC in every state.
- Address stability: while imemREN = 1 and ihit = 0, imemaddr must not change.
- RUN:
  - ihit & redirect_en: flushed = 1; PC <= redirect_addr, regardless of stall.
  - ihit & !redirect_en & !stall: PC <= PC + 4.
  - ihit & stall: PC holds.
  - !ihit & redirect_en: buffered target <= redirect_addr; go to REDIR_PEND; PC holds.
- REDIR_PEND:
  - redirect_en without ihit: buffered target is overwritten; the latest redirect wins.
  - ihit: flushed = 1; PC <= redirect_addr if redirect_en, else the buffered target; go to RUN.
- halt: from any state, go to HALTED at the next edge. halt has priority over redirect and ihit. HALTED is left only by reset.
- flushed is combinational: ihit & (redirect_en | state == REDIR_PEND). It is 0 in HALTED.
- Arithmetic:
  - npc = PC + 4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
  - redirect_addr[1:0] is forced to 2'b00 when loaded.
- Counters:
  - fetch_cnt increments on ihit & !flushed & !stall & state != HALTED.
  - flush_cnt increments on ihit & flushed.
  - Both saturate at 32'hFFFF_FFFF.

## Timing
- One-cycle fetch on a hit: PC updates at the posedge ending the ihit cycle. The IF/ID latch captures imemload/npc/PC at that same edge.
- Redirect penalty:
  - Hit: 1 bubble.
  - Miss: 1 bubble, taken when the pending miss completes; no extra cycles beyond the miss latency.
- Asynchronous reset mid-miss: state, PC and counters clear immediately. imemaddr = PC_RESET in the first cycle after release.
- Simultaneous halt + redirect_en + ihit: next state is HALTED. PC takes the redirect value. flushed = 1 in that cycle.

## Structure
- `fetch_state_t` (RUN, REDIR_PEND, HALTED) goes in `cpu_types_pkg`, alongside `word_t`.
- The PC increment constant 4 is defined in the same package.
- Sub-module `sat_counter` (parameter WIDTH, inputs inc/clear, output count) is instantiated twice, once for fetch_cnt and once for flush_cnt.

## Test plan
- Reset with PC_RESET = 32'h0000_0040, then 3 consecutive ihit cycles -> imemaddr steps 0x40, 0x44, 0x48, 0x4C; npc = PC + 4; fetch_cnt = 3.
- ihit with stall = 1 for 2 cycles -> PC holds 0x44 and fetch_cnt does not change; after stall drops, PC advances to 0x48.
- redirect_en with redirect_addr = 0x100 during an ihit -> flushed = 1 that cycle; next imemaddr = 0x100; flush_cnt = 1.
- Miss of 4 cycles on 0x20:
  - redirect_en with 0x200 in miss cycle 1, then 0x300 in miss cycle 3 -> imemaddr stays 0x20 throughout the miss.
  - At the ihit: flushed = 1.
  - Next cycle: imemaddr = 0x300.
- halt asserted -> imemREN = 0 from the next cycle; PC frozen; a later redirect_en is ignored.
- Redirect to 0xFFFF_FFFC followed by an ihit -> PC wraps to 0x0. A redirect_addr of 0x103 loads as 0x100.
